// File: rtl/serial_addsub_unit_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: default width and
// the controller state encoding (the unused code 2'd3 falls back to IDLE).
package serial_addsub_unit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_gate.sv
// Single-bit full adder cell, shared across all bit positions of the serial unit.
module full_adder_gate (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: one full adder reused for WIDTH cycles, LSB first,
// with valid/ready handshakes on both the request and the response side.
module serial_addsub_unit
    import serial_addsub_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             sub_r;
    logic             msb_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic             pre_msb_bit;

    full_adder_gate u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
    assign pre_msb_bit = (cnt == CNT_W'(WIDTH - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Subtraction is a + ~b + !cin; the borrow is the inverted final carry,
    // while overflow uses the raw carries into and out of the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            sub_r    <= 1'b0;
            msb_cin  <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        sub_r <= sub;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    result <= {fa_sum, result[WIDTH-1:1]};
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (pre_msb_bit) begin
                        msb_cin <= fa_cout;
                    end
                    if (last_bit) begin
                        cout     <= fa_cout ^ sub_r;
                        overflow <= msb_cin ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
